// File: rtl/filtro_iir_secuenciador.sv
// Sequencer for a biquad IIR datapath: one shared multiplier and accumulator walk the five
// filter terms, then the result is saturated to W bits and pushed into the x/y history.
module filtro_iir_secuenciador #(
    parameter int unsigned W     = 25,
    parameter int unsigned FRAC  = 14,
    parameter int unsigned ACC_W = 36
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic signed [W-1:0] x_in,
    input  logic signed [W-1:0] Constantes,
    output logic [2:0]          selector,
    output logic signed [W-1:0] y_out,
    output logic                done,
    output logic                busy,
    output logic                sat
);

    typedef enum logic [2:0] {
        StIdle,
        StB0,
        StB1,
        StB2,
        StA1,
        StA2,
        StSat
    } state_e;

    localparam logic [2:0] SelA1   = 3'b000;
    localparam logic [2:0] SelA2   = 3'b001;
    localparam logic [2:0] SelB0   = 3'b010;
    localparam logic [2:0] SelB1   = 3'b011;
    localparam logic [2:0] SelB2   = 3'b100;
    localparam logic [2:0] SelZero = 3'b110;

    state_e state_q, state_d;
    logic [2:0] selector_q, selector_d;

    logic signed [W-1:0]     x0_q, x0_d, x1_q, x1_d, x2_q, x2_d;
    logic signed [W-1:0]     y1_q, y1_d, y2_q, y2_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;

    logic signed [W-1:0] y_q, y_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                sat_q, sat_d;

    logic signed [W-1:0]   operand;
    logic signed [2*W-1:0] product;
    logic signed [2*W-1:0] product_scaled;

    logic                sat_hi, sat_lo;
    logic signed [W-1:0] y_sat;

    // Selector is a function of the state being entered, so it is stable for the whole state.
    function automatic logic [2:0] sel_of(input state_e s);
        logic [2:0] sel;
        sel = SelZero;
        unique case (s)
            StB0:    sel = SelB0;
            StB1:    sel = SelB1;
            StB2:    sel = SelB2;
            StA1:    sel = SelA1;
            StA2:    sel = SelA2;
            default: sel = SelZero;
        endcase
        return sel;
    endfunction

    always_comb begin
        operand = '0;
        unique case (state_q)
            StB0:    operand = x0_q;
            StB1:    operand = x1_q;
            StB2:    operand = x2_q;
            StA1:    operand = y1_q;
            StA2:    operand = y2_q;
            default: operand = '0;
        endcase
    end

    always_comb begin
        product        = operand * Constantes;
        product_scaled = product >>> FRAC;
    end

    // Out of range when the bits above the W-bit sign position disagree with the sign.
    always_comb begin
        sat_hi = ~acc_q[ACC_W-1] & (|acc_q[ACC_W-2:W-1]);
        sat_lo = acc_q[ACC_W-1] & ~(&acc_q[ACC_W-2:W-1]);
        if (sat_hi) begin
            y_sat = {1'b0, {(W-1){1'b1}}};
        end else if (sat_lo) begin
            y_sat = {1'b1, {(W-1){1'b0}}};
        end else begin
            y_sat = acc_q[W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        y1_d    = y1_q;
        y2_d    = y2_q;
        y_d     = y_q;
        done_d  = 1'b0;
        sat_d   = 1'b0;
        busy_d  = busy_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    x0_d    = x_in;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StB0;
                end
            end
            StB0: begin
                acc_d   = acc_q + product_scaled[ACC_W-1:0];
                state_d = StB1;
            end
            StB1: begin
                acc_d   = acc_q + product_scaled[ACC_W-1:0];
                state_d = StB2;
            end
            StB2: begin
                acc_d   = acc_q + product_scaled[ACC_W-1:0];
                state_d = StA1;
            end
            StA1: begin
                acc_d   = acc_q + product_scaled[ACC_W-1:0];
                state_d = StA2;
            end
            StA2: begin
                acc_d   = acc_q + product_scaled[ACC_W-1:0];
                state_d = StSat;
            end
            StSat: begin
                y_d     = y_sat;
                sat_d   = sat_hi | sat_lo;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                x2_d    = x1_q;
                x1_d    = x0_q;
                y2_d    = y1_q;
                y1_d    = y_sat;
                state_d = StIdle;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase

        selector_d = sel_of(state_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            selector_q <= SelZero;
            x0_q       <= '0;
            x1_q       <= '0;
            x2_q       <= '0;
            y1_q       <= '0;
            y2_q       <= '0;
            acc_q      <= '0;
            y_q        <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            selector_q <= selector_d;
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            y1_q       <= y1_d;
            y2_q       <= y2_d;
            acc_q      <= acc_d;
            y_q        <= y_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            sat_q      <= sat_d;
        end
    end

    assign selector = selector_q;
    assign y_out    = y_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign sat      = sat_q;

endmodule

// File: tb/tb_filtro_iir_secuenciador.sv
// Directed and randomized bench for filtro_iir_secuenciador; the constant mux and the filter
// equation are modelled here with plain integer arithmetic.
module tb_filtro_iir_secuenciador;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [24:0] x_in = '0;
    logic [24:0] Constantes;
    logic [2:0]  selector;
    logic [24:0] y_out;
    logic        done;
    logic        busy;
    logic        sat;

    logic signed [24:0] coef [8];
    logic [2:0] trace [5];

    int n_cmp = 0;
    int n_err = 0;

    // Reference history: previous inputs and outputs as plain integers.
    longint xp1, xp2, yp1, yp2;
    logic [24:0] exp_y;
    logic        exp_sat;
    logic [24:0] last_y;

    filtro_iir_secuenciador dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .x_in       (x_in),
        .Constantes (Constantes),
        .selector   (selector),
        .y_out      (y_out),
        .done       (done),
        .busy       (busy),
        .sat        (sat)
    );

    always #5 clk = ~clk;

    assign Constantes = (selector == 3'b110) ? 25'd0 : coef[selector];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic longint floor_q(input longint p);
        longint q;
        q = p / 16384;
        if ((p % 16384) != 0 && p < 0) q = q - 1;
        return q;
    endfunction

    function automatic longint c(input int i);
        return longint'(coef[i]);
    endfunction

    task automatic set_coef(input int b0, input int b1, input int b2, input int a1, input int a2);
        coef[2] = 25'(b0);
        coef[3] = 25'(b1);
        coef[4] = 25'(b2);
        coef[0] = 25'(a1);
        coef[1] = 25'(a2);
        coef[5] = 25'(12345);
        coef[6] = 25'(777);
        coef[7] = 25'(-4321);
    endtask

    task automatic model_clear();
        xp1 = 0;
        xp2 = 0;
        yp1 = 0;
        yp2 = 0;
    endtask

    task automatic model_sample(input logic signed [24:0] x);
        longint xv, acc, yv;
        xv  = longint'(x);
        acc = floor_q(c(2) * xv) + floor_q(c(3) * xp1) + floor_q(c(4) * xp2)
            + floor_q(c(0) * yp1) + floor_q(c(1) * yp2);
        exp_sat = 1'b0;
        if (acc > 64'sd16777215) begin
            yv = 16777215;
            exp_sat = 1'b1;
        end else if (acc < -64'sd16777216) begin
            yv = -16777216;
            exp_sat = 1'b1;
        end else begin
            yv = acc;
        end
        exp_y = 25'(yv);
        xp2 = xp1;
        xp1 = xv;
        yp2 = yp1;
        yp1 = yv;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    // One full sample; optionally re-pulses start during B2 with another value.
    task automatic run_sample(input logic [24:0] x, input bit glitch, input logic [24:0] xg);
        int extra;
        model_sample(x);
        @(negedge clk);
        start = 1'b1;
        x_in  = x;
        @(posedge clk);
        #1;
        start = 1'b0;
        x_in  = ~x;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            check("busy_during", busy, 1);
            check("done_early", done, 0);
            if (cyc <= 5) check("selector_trace", selector, trace[cyc-1]);
            if (glitch && cyc == 3) begin
                start = 1'b1;
                x_in  = xg;
            end
            if (glitch && cyc == 4) start = 1'b0;
            @(posedge clk);
            #1;
        end
        check("done_at_e6", done, 1);
        check("busy_at_e6", busy, 0);
        check("y_out", y_out, exp_y);
        check("sat", sat, exp_sat);
        @(posedge clk);
        #1;
        check("done_one_cycle", done, 0);
        check("sat_clears", sat, 0);
        check("y_out_holds", y_out, exp_y);
        check("selector_idle", selector, 3'b110);
        if (glitch) begin
            extra = 0;
            for (int k = 0; k < 10; k++) begin
                if (done) extra++;
                @(posedge clk);
                #1;
            end
            check("no_second_done", extra, 0);
            check("y_out_first_sample", y_out, exp_y);
        end
        last_y = exp_y;
    endtask

    initial begin
        logic signed [24:0] rx;
        int dn;

        trace[0] = 3'b010;
        trace[1] = 3'b011;
        trace[2] = 3'b100;
        trace[3] = 3'b000;
        trace[4] = 3'b001;
        set_coef(0, 0, 0, 0, 0);
        model_clear();
        last_y = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_selector", selector, 3'b110);
        check("rst_y_out", y_out, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_sat", sat, 0);
        @(negedge clk);
        reset = 1'b0;

        // Pass-through
        set_coef(16384, 0, 0, 0, 0);
        run_sample(25'd1000, 1'b0, '0);

        // FIR history
        reset_dut();
        set_coef(8192, 8192, 8192, 0, 0);
        run_sample(25'd100, 1'b0, '0);
        run_sample(25'd200, 1'b0, '0);

        // Integrator
        reset_dut();
        set_coef(16384, 0, 0, 16384, 0);
        run_sample(25'd10, 1'b0, '0);
        run_sample(25'd0, 1'b0, '0);
        run_sample(25'd0, 1'b0, '0);

        // Rounding toward minus infinity and both saturation limits
        reset_dut();
        set_coef(8192, 0, 0, 0, 0);
        run_sample(25'h1FFFFFF, 1'b0, '0);
        set_coef(32768, 0, 0, 0, 0);
        run_sample(25'h0FFFFFF, 1'b0, '0);
        run_sample(25'h1000000, 1'b0, '0);

        // Start ignored while busy
        reset_dut();
        set_coef(16384, 0, 0, 0, 0);
        run_sample(25'd321, 1'b1, 25'd9999);

        // Reset during A1 aborts the sample and clears the history
        set_coef(16384, 16384, 0, 0, 0);
        @(negedge clk);
        start = 1'b1;
        x_in  = 25'd77;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        check("abort_selector", selector, 3'b110);
        check("abort_y_out", y_out, 0);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        check("abort_sat", sat, 0);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        dn = 0;
        for (int k = 0; k < 10; k++) begin
            if (done) dn++;
            @(posedge clk);
            #1;
        end
        check("abort_no_done", dn, 0);
        run_sample(25'd5, 1'b0, '0);

        // Randomized coefficients and samples against the reference model
        for (int n = 0; n < 24; n++) begin
            set_coef(int'($urandom_range(0, 40000)) - 20000,
                     int'($urandom_range(0, 40000)) - 20000,
                     int'($urandom_range(0, 40000)) - 20000,
                     int'($urandom_range(0, 24000)) - 12000,
                     int'($urandom_range(0, 24000)) - 12000);
            rx = 25'($urandom);
            rx = rx >>> $urandom_range(0, 14);
            run_sample(rx, 1'b0, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
